// File: rtl/spm_pkg.sv
// Shared definitions for the stored-program machine processing unit:
// ALU opcodes, Bus_2 source encodings, flag bundle and multiplier states.
package spm_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_RD  = 4'd5;
   localparam logic [3:0] OP_WR  = 4'd6;
   localparam logic [3:0] OP_BR  = 4'd7;
   localparam logic [3:0] OP_BRZ = 4'd8;
   localparam logic [3:0] OP_OR  = 4'd9;
   localparam logic [3:0] OP_XOR = 4'd10;
   localparam logic [3:0] OP_SHL = 4'd11;
   localparam logic [3:0] OP_SHR = 4'd12;

   localparam logic [1:0] B2_ALU  = 2'd0;
   localparam logic [1:0] B2_BUS1 = 2'd1;
   localparam logic [1:0] B2_MEM  = 2'd2;
   localparam logic [1:0] B2_PROD = 2'd3;

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
      logic overflow;
   } spm_flags_t;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_RUN,
      MUL_DONE
   } mul_state_e;

endpackage

// File: rtl/spm_processing_unit_p_if.sv
// Memory-unit bus and multiplier handshake of the processing unit.
// The master side is the control/memory environment; the slave side is the unit.
interface spm_processing_unit_p_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] memory_word;
   logic [WORD_W-1:0] instruction;
   logic [WORD_W-1:0] address;
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [WORD_W-1:0] mul_hi;

   modport master (
      output memory_word, mul_start,
      input  instruction, address, mul_busy, mul_done, mul_hi
   );

   modport slave (
      input  memory_word, mul_start,
      output instruction, address, mul_busy, mul_done, mul_hi
   );
endinterface

// File: rtl/spm_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle,
// with a start/busy/done handshake. Product holds until the next completion.
module spm_seq_multiplier
   import spm_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_W-1:0]     op_a,
   input  logic [WORD_W-1:0]     op_b,
   output logic                  busy,
   output logic                  done,
   output logic [2*WORD_W-1:0]   product
);
   localparam int CNT_W = $clog2(WORD_W + 1);

   mul_state_e          state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WORD_W-1:0]   mcand_q, mcand_d;
   logic [2*WORD_W-1:0] acc_q, acc_d;
   logic [2*WORD_W-1:0] product_q, product_d;
   logic [WORD_W:0]     partial;

   // Accumulator starts as {0, multiplier}; each step adds the multiplicand
   // into the upper half when the current LSB is set, then shifts right.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      count_d   = count_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      partial   = {1'b0, acc_q[2*WORD_W-1:WORD_W]}
                + (acc_q[0] ? {1'b0, mcand_q} : '0);
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               mcand_d = op_a;
               acc_d   = {{WORD_W{1'b0}}, op_b};
               count_d = CNT_W'(WORD_W);
               state_d = MUL_RUN;
            end
         end
         MUL_RUN: begin
            if (count_q != '0) begin
               acc_d   = {partial, acc_q[WORD_W-1:1]};
               count_d = count_q - 1'b1;
            end else begin
               product_d = acc_q;
               state_d   = MUL_DONE;
            end
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= MUL_IDLE;
         count_q   <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == MUL_RUN);
   assign done    = (state_q == MUL_DONE);
   assign product = product_q;

endmodule

// File: rtl/spm_processing_unit_p.sv
// Next-generation processing unit: register file, PC/IR/address/Reg_Y,
// Z/C/N/V flags, extended ALU and an attached sequential multiplier.
module spm_processing_unit_p
   import spm_pkg::*;
#(
   parameter  int WORD_W   = 8,
   parameter  int OP_W     = 4,
   parameter  int NUM_REGS = 4,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reg_we,
   input  logic [SEL_W-1:0]    reg_wsel,
   input  logic [SEL_W:0]      bus1_sel,
   input  logic [1:0]          bus2_sel,
   input  logic                load_pc,
   input  logic                inc_pc,
   input  logic                load_ir,
   input  logic                load_addr,
   input  logic                load_y,
   input  logic                load_flags,
   output logic                zero,
   output logic                carry,
   output logic                negative,
   output logic                overflow,
   spm_processing_unit_p_if.slave bus
);
   localparam int MSB = WORD_W - 1;

   logic [WORD_W-1:0]   regs_q [NUM_REGS];
   logic [WORD_W-1:0]   regs_d [NUM_REGS];
   logic [WORD_W-1:0]   pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, y_q, y_d;
   spm_flags_t          flags_q, flags_d, alu_flags;
   logic [WORD_W-1:0]   bus1, bus2, alu_res;
   logic [WORD_W:0]     sum, diff;
   logic [OP_W-1:0]     opcode;
   logic [SEL_W-1:0]    rd_idx;
   logic [2*WORD_W-1:0] product;

   assign opcode = ir_q[WORD_W-1 -: OP_W];
   assign rd_idx = bus1_sel[SEL_W-1:0];

   always_comb begin
      bus1 = '0;
      if (bus1_sel[SEL_W])
         bus1 = pc_q;
      else if (int'(rd_idx) < NUM_REGS)
         bus1 = regs_q[rd_idx];
   end

   // ALU: A = Bus_1, B = Reg_Y. Carry doubles as borrow for SUB.
   always_comb begin
      sum       = {1'b0, bus1} + {1'b0, y_q};
      diff      = {1'b0, bus1} - {1'b0, y_q};
      alu_res   = '0;
      alu_flags = '0;
      case (opcode)
         OP_ADD: begin
            alu_res            = sum[MSB:0];
            alu_flags.carry    = sum[WORD_W];
            alu_flags.overflow = (bus1[MSB] == y_q[MSB]) && (alu_res[MSB] != bus1[MSB]);
         end
         OP_SUB: begin
            alu_res            = diff[MSB:0];
            alu_flags.carry    = diff[WORD_W];
            alu_flags.overflow = (bus1[MSB] != y_q[MSB]) && (alu_res[MSB] != bus1[MSB]);
         end
         OP_AND: alu_res = bus1 & y_q;
         OP_NOT: alu_res = ~bus1;
         OP_OR:  alu_res = bus1 | y_q;
         OP_XOR: alu_res = bus1 ^ y_q;
         OP_SHL: begin
            alu_res         = {bus1[MSB-1:0], 1'b0};
            alu_flags.carry = bus1[MSB];
         end
         OP_SHR: begin
            alu_res         = {1'b0, bus1[MSB:1]};
            alu_flags.carry = bus1[0];
         end
         default: alu_res = '0;
      endcase
      alu_flags.zero     = (alu_res == '0);
      alu_flags.negative = alu_res[MSB];
   end

   always_comb begin
      case (bus2_sel)
         B2_ALU:  bus2 = alu_res;
         B2_BUS1: bus2 = bus1;
         B2_MEM:  bus2 = bus.memory_word;
         default: bus2 = product[WORD_W-1:0];
      endcase
   end

   always_comb begin
      regs_d = regs_q;
      if (reg_we && (int'(reg_wsel) < NUM_REGS))
         regs_d[reg_wsel] = bus2;
      if (load_pc)     pc_d = bus2;
      else if (inc_pc) pc_d = pc_q + 1'b1;
      else             pc_d = pc_q;
      ir_d    = load_ir    ? bus2      : ir_q;
      addr_d  = load_addr  ? bus2      : addr_q;
      y_d     = load_y     ? bus2      : y_q;
      flags_d = load_flags ? alu_flags : flags_q;
   end

   // NOTE: the register file is reset with the other state because software relies on R0..Rn reading 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q  <= '{default: '0};
         pc_q    <= '0;
         ir_q    <= '0;
         addr_q  <= '0;
         y_q     <= '0;
         flags_q <= '0;
      end else begin
         regs_q  <= regs_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         y_q     <= y_d;
         flags_q <= flags_d;
      end
   end

   spm_seq_multiplier #(.WORD_W(WORD_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (bus.mul_start),
      .op_a    (y_q),
      .op_b    (bus1),
      .busy    (bus.mul_busy),
      .done    (bus.mul_done),
      .product (product)
   );

   assign bus.instruction = ir_q;
   assign bus.address     = addr_q;
   assign bus.mul_hi      = product[2*WORD_W-1:WORD_W];
   assign zero            = flags_q.zero;
   assign carry           = flags_q.carry;
   assign negative        = flags_q.negative;
   assign overflow        = flags_q.overflow;

endmodule

// File: tb/tb_spm_processing_unit_p.sv
// Directed bench for spm_processing_unit_p: internal values are observed by
// routing them over Bus_2 into the address register.
module tb_spm_processing_unit_p;

   logic       clk;
   logic       rst;
   logic       reg_we;
   logic [1:0] reg_wsel;
   logic [2:0] bus1_sel;
   logic [1:0] bus2_sel;
   logic       load_pc, inc_pc, load_ir, load_addr, load_y, load_flags;
   logic       zero, carry, negative, overflow;

   int n_cmp = 0;
   int n_err = 0;

   spm_processing_unit_p_if #(.WORD_W(8)) bus_if ();

   spm_processing_unit_p #(.WORD_W(8), .OP_W(4), .NUM_REGS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_we     (reg_we),
      .reg_wsel   (reg_wsel),
      .bus1_sel   (bus1_sel),
      .bus2_sel   (bus2_sel),
      .load_pc    (load_pc),
      .inc_pc     (inc_pc),
      .load_ir    (load_ir),
      .load_addr  (load_addr),
      .load_y     (load_y),
      .load_flags (load_flags),
      .zero       (zero),
      .carry      (carry),
      .negative   (negative),
      .overflow   (overflow),
      .bus        (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reg_we = 0; reg_wsel = 0; bus1_sel = 0; bus2_sel = 0;
      load_pc = 0; inc_pc = 0; load_ir = 0; load_addr = 0; load_y = 0; load_flags = 0;
      bus_if.mul_start = 0; bus_if.memory_word = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input int idx, input logic [7:0] v);
      idle(); bus2_sel = 2; bus_if.memory_word = v; reg_we = 1; reg_wsel = 2'(idx);
      tick(); idle();
   endtask

   task automatic set_y(input logic [7:0] v);
      idle(); bus2_sel = 2; bus_if.memory_word = v; load_y = 1; tick(); idle();
   endtask

   task automatic set_ir(input logic [7:0] v);
      idle(); bus2_sel = 2; bus_if.memory_word = v; load_ir = 1; tick(); idle();
   endtask

   task automatic set_pc(input logic [7:0] v);
      idle(); bus2_sel = 2; bus_if.memory_word = v; load_pc = 1; tick(); idle();
   endtask

   // Copies Bus_1 into the address register.
   task automatic read_bus1(input logic [2:0] sel);
      idle(); bus1_sel = sel; bus2_sel = 1; load_addr = 1; tick(); idle();
   endtask

   // Copies the ALU result into the address register, optionally loading flags.
   task automatic alu_op(input logic [2:0] sel, input logic fl);
      idle(); bus1_sel = sel; bus2_sel = 0; load_addr = 1; load_flags = fl; tick(); idle();
   endtask

   initial begin
      int n;
      int done_cnt;
      rst = 1'b0;
      idle();
      #12 rst = 1'b1;
      tick();

      check("reset_address", bus_if.address, 16'h00);
      check("reset_instruction", bus_if.instruction, 16'h00);
      check("reset_flags", {zero, carry, negative, overflow}, 16'h0);
      check("reset_mul", {bus_if.mul_busy, bus_if.mul_done, bus_if.mul_hi}, 16'h0);

      // Populate state, then assert reset asynchronously mid-cycle.
      write_reg(0, 8'h11); write_reg(1, 8'h22); write_reg(2, 8'h33); write_reg(3, 8'h44);
      set_pc(8'h20);
      set_ir(8'h20); set_y(8'h11);
      alu_op(3'd0, 1'b1);
      read_bus1(3'b100);
      check("pc_before_reset", bus_if.address, 16'h20);
      check("flags_before_reset", {zero, carry, negative, overflow}, 16'h8);
      #3 rst = 1'b0;
      #1;
      check("async_rst_address", bus_if.address, 16'h00);
      check("async_rst_instruction", bus_if.instruction, 16'h00);
      check("async_rst_flags", {zero, carry, negative, overflow}, 16'h0);
      check("async_rst_busy", bus_if.mul_busy, 16'h0);
      #2 rst = 1'b1;
      read_bus1(3'd3);
      check("async_rst_r3", bus_if.address, 16'h00);
      read_bus1(3'b100);
      check("async_rst_pc", bus_if.address, 16'h00);

      // ADD: signed overflow, then carry-out to zero.
      set_ir(8'h10); set_y(8'h7F); write_reg(1, 8'h01);
      alu_op(3'd1, 1'b1);
      check("add_ovf_result", bus_if.address, 16'h80);
      check("add_ovf_flags", {zero, carry, negative, overflow}, 16'h3);
      set_y(8'hFF);
      alu_op(3'd1, 1'b1);
      check("add_carry_result", bus_if.address, 16'h00);
      check("add_carry_flags", {zero, carry, negative, overflow}, 16'hC);

      // SUB: equal operands, then borrow.
      set_ir(8'h20); write_reg(2, 8'h05); set_y(8'h05);
      alu_op(3'd2, 1'b1);
      check("sub_zero_result", bus_if.address, 16'h00);
      check("sub_zero_flags", {zero, carry, negative, overflow}, 16'h8);
      write_reg(2, 8'h03);
      alu_op(3'd2, 1'b1);
      check("sub_borrow_result", bus_if.address, 16'hFE);
      check("sub_borrow_flags", {zero, carry, negative, overflow}, 16'h6);

      // Shifts, logic ops, flag hold and a control-only opcode.
      set_ir(8'hC0); write_reg(0, 8'h81);
      alu_op(3'd0, 1'b1);
      check("shr_result", bus_if.address, 16'h40);
      check("shr_flags", {zero, carry, negative, overflow}, 16'h4);
      set_ir(8'h30);
      alu_op(3'd0, 1'b0);
      check("and_result", bus_if.address, 16'h01);
      check("flags_hold", {zero, carry, negative, overflow}, 16'h4);
      set_ir(8'hA0);
      alu_op(3'd0, 1'b1);
      check("xor_result", bus_if.address, 16'h84);
      check("xor_flags", {zero, carry, negative, overflow}, 16'h2);
      set_ir(8'hB0);
      alu_op(3'd0, 1'b1);
      check("shl_result", bus_if.address, 16'h02);
      check("shl_flags", {zero, carry, negative, overflow}, 16'h4);
      set_ir(8'h70);
      alu_op(3'd0, 1'b1);
      check("br_result", bus_if.address, 16'h00);
      check("br_flags", {zero, carry, negative, overflow}, 16'h8);

      // Multiply 0xFF x 0xFF = 0xFE01; a second start mid-run (with new
      // operands loaded the same cycle) must be ignored.
      set_y(8'hFF); write_reg(3, 8'hFF);
      idle(); bus1_sel = 3'd3; bus_if.mul_start = 1; tick(); idle();
      check("mul_busy_start", {bus_if.mul_busy, bus_if.mul_done}, 16'h2);
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) begin
            bus_if.mul_start = 1; bus1_sel = 3'd0; bus2_sel = 2;
            bus_if.memory_word = 8'h02; load_y = 1;
         end
         tick(); idle();
      end
      check("mul_busy_edge8", {bus_if.mul_busy, bus_if.mul_done}, 16'h2);
      tick();
      check("mul_done_edge9", {bus_if.mul_busy, bus_if.mul_done}, 16'h1);
      check("mul_hi", bus_if.mul_hi, 16'hFE);
      bus2_sel = 3; load_addr = 1; tick(); idle();
      check("mul_lo", bus_if.address, 16'h01);
      check("mul_done_pulse_end", {bus_if.mul_busy, bus_if.mul_done}, 16'h0);

      // PC: load beats increment, increment, wrap.
      idle(); bus2_sel = 2; bus_if.memory_word = 8'h40; load_pc = 1; inc_pc = 1; tick(); idle();
      read_bus1(3'b100);
      check("pc_load_priority", bus_if.address, 16'h40);
      idle(); inc_pc = 1; tick(); idle();
      read_bus1(3'b100);
      check("pc_inc", bus_if.address, 16'h41);
      set_pc(8'hFF);
      idle(); inc_pc = 1; tick(); idle();
      read_bus1(3'b100);
      check("pc_wrap", bus_if.address, 16'h00);

      // Simultaneous loads share Bus_2.
      idle(); bus2_sel = 2; bus_if.memory_word = 8'h9A;
      load_ir = 1; load_addr = 1; load_y = 1; reg_we = 1; reg_wsel = 2'd1;
      tick(); idle();
      check("multi_load_addr", bus_if.address, 16'h9A);
      check("multi_load_ir", bus_if.instruction, 16'h9A);
      read_bus1(3'd1);
      check("multi_load_r1", bus_if.address, 16'h9A);

      // Abort a multiply with reset while the counter is at 3.
      set_y(8'h0D); write_reg(1, 8'h0B);
      idle(); bus1_sel = 3'd1; bus_if.mul_start = 1; tick(); idle();
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b0;
      #1;
      check("abort_busy", bus_if.mul_busy, 16'h0);
      check("abort_mul_hi", bus_if.mul_hi, 16'h00);
      #2 rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus_if.mul_done) done_cnt++;
      end
      check("abort_no_done", done_cnt[15:0], 16'h0);
      idle(); bus2_sel = 3; load_addr = 1; tick(); idle();
      check("abort_product_lo", bus_if.address, 16'h00);

      // Fresh multiply after abort: 13 x 11 = 0x008F, done after edge 9.
      set_y(8'h0D); write_reg(1, 8'h0B);
      idle(); bus1_sel = 3'd1; bus_if.mul_start = 1; tick(); idle();
      n = 0;
      while (!bus_if.mul_done && n < 20) begin
         tick();
         n++;
      end
      check("remul_done_seen", bus_if.mul_done, 16'h1);
      check("remul_latency", n[15:0], 16'd9);
      check("remul_hi", bus_if.mul_hi, 16'h00);
      idle(); bus2_sel = 3; load_addr = 1; tick(); idle();
      check("remul_lo", bus_if.address, 16'h8F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
